smi_mem_lib_write_test_sequencer64: RTL

SMI_MEM_LIB_WRITE_TEST_SEQUENCER64 -- requirements
Module: smiMemLibWriteTestSequencer64

---
 rtl/smi_mem_lib_write_test_sequencer64.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/smi_mem_lib_write_test_sequencer64.sv
// smi_mem_lib_write_test_sequencer64
//
// Runs a sequence of write-test bursts. It accepts one sequence request,
// issues seqBurstCount bursts to the test source one at a time, counts the
// bursts that report a bad status, and returns a single summary result.
//
// Burst k uses address seqBaseAddr + k*seqAddrStride (64-bit, wrapping) and
// data seed seqDataInit + k (64-bit, wrapping). Length, options and data
// increment are forwarded exactly as captured.
//
// Ports
//   clk, srst_n            clock; asynchronous active-low reset
//   seqParams*             sequence request (valid/stop handshake)
//   seqDone*               sequence result (valid/stop handshake)
//   testParam*             per-burst command to the test source
//   testDone*              per-burst status from the test source
//
// Build option
//   SMI_SEQ_STOP_ON_ERROR_EN  when defined, the first failing burst ends the
//                             sequence and the remaining bursts are skipped.

module smi_mem_lib_write_test_sequencer64 #(
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   srst_n,

    input  logic                   seqParamsValid,
    input  logic [63:0]            seqBaseAddr,
    input  logic [31:0]            seqAddrStride,
    input  logic [31:0]            seqBurstLen,
    input  logic [7:0]             seqBurstOpts,
    input  logic [COUNT_WIDTH-1:0] seqBurstCount,
    input  logic [63:0]            seqDataInit,
    input  logic [63:0]            seqDataIncr,
    output logic                   seqParamsStop,

    output logic                   seqDoneValid,
    output logic                   seqDoneStatusOk,
    output logic [COUNT_WIDTH-1:0] seqDoneFailCount,
    input  logic                   seqDoneStop,

    output logic                   testParamsValid,
    output logic [63:0]            testParamBurstAddr,
    output logic [31:0]            testParamBurstLen,
    output logic [7:0]             testParamBurstOpts,
    output logic [63:0]            testParamDataInit,
    output logic [63:0]            testParamDataIncr,
    input  logic                   testParamsStop,

    input  logic                   testDoneValid,
    input  logic                   testDoneStatusOk,
    output logic                   testDoneStop
);

    typedef enum logic [1:0] {
        SeqIdle,
        SeqIssue,
        SeqWait,
        SeqReport
    } seqState_t;

    seqState_t state;
    seqState_t stateNext;

    logic [63:0]            addrCur;
    logic [63:0]            dataCur;
    logic [63:0]            dataIncr;
    logic [31:0]            addrStride;
    logic [31:0]            burstLen;
    logic [7:0]             burstOpts;
    logic [COUNT_WIDTH-1:0] burstCount;
    logic [COUNT_WIDTH-1:0] burstIdx;
    logic [COUNT_WIDTH-1:0] failCount;

    logic seqAccept;
    logic issueAccept;
    logic doneAccept;
    logic reportAccept;
    logic lastBurst;
    logic stopOnErr;

`ifdef SMI_SEQ_STOP_ON_ERROR_EN
    assign stopOnErr = 1'b1;
`else
    assign stopOnErr = 1'b0;
`endif

    assign seqAccept    = (state == SeqIdle)   && seqParamsValid;
    assign issueAccept  = (state == SeqIssue)  && !testParamsStop;
    assign doneAccept   = (state == SeqWait)   && testDoneValid;
    assign reportAccept = (state == SeqReport) && !seqDoneStop;

    // Compared one bit wider so a count of all-ones cannot overflow k+1.
    assign lastBurst = ({1'b0, burstIdx} + {{COUNT_WIDTH{1'b0}}, 1'b1})
                       >= {1'b0, burstCount};

    always_ff @(posedge clk or negedge srst_n) begin
        if (!srst_n) begin
            state <= SeqIdle;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext       = state;
        seqParamsStop   = 1'b1;
        testParamsValid = 1'b0;
        testDoneStop    = 1'b1;
        seqDoneValid    = 1'b0;
        seqDoneStatusOk = 1'b0;
        case (state)
            SeqIdle: begin
                seqParamsStop = 1'b0;
                if (seqAccept) begin
                    stateNext = (seqBurstCount != '0) ? SeqIssue : SeqReport;
                end
            end
            SeqIssue: begin
                testParamsValid = 1'b1;
                if (issueAccept) begin
                    stateNext = SeqWait;
                end
            end
            SeqWait: begin
                testDoneStop = 1'b0;
                if (doneAccept) begin
                    if (lastBurst || (stopOnErr && !testDoneStatusOk)) begin
                        stateNext = SeqReport;
                    end else begin
                        stateNext = SeqIssue;
                    end
                end
            end
            SeqReport: begin
                seqDoneValid    = 1'b1;
                seqDoneStatusOk = (failCount == '0);
                if (reportAccept) begin
                    stateNext = SeqIdle;
                end
            end
            default: stateNext = SeqIdle;
        endcase
    end

    // Burst address and data seed are kept as running sums rather than
    // multiplied out, so only adders are needed.
    always_ff @(posedge clk or negedge srst_n) begin
        if (!srst_n) begin
            addrCur    <= '0;
            dataCur    <= '0;
            dataIncr   <= '0;
            addrStride <= '0;
            burstLen   <= '0;
            burstOpts  <= '0;
            burstCount <= '0;
            burstIdx   <= '0;
            failCount  <= '0;
        end else if (seqAccept) begin
            addrCur    <= seqBaseAddr;
            dataCur    <= seqDataInit;
            dataIncr   <= seqDataIncr;
            addrStride <= seqAddrStride;
            burstLen   <= seqBurstLen;
            burstOpts  <= seqBurstOpts;
            burstCount <= seqBurstCount;
            burstIdx   <= '0;
            failCount  <= '0;
        end else if (doneAccept) begin
            burstIdx <= burstIdx + COUNT_WIDTH'(1);
            addrCur  <= addrCur + {32'h0, addrStride};
            dataCur  <= dataCur + 64'd1;
            if (!testDoneStatusOk && (failCount != '1)) begin
                failCount <= failCount + COUNT_WIDTH'(1);
            end
        end
    end

    assign testParamBurstAddr = addrCur;
    assign testParamBurstLen  = burstLen;
    assign testParamBurstOpts = burstOpts;
    assign testParamDataInit  = dataCur;
    assign testParamDataIncr  = dataIncr;
    assign seqDoneFailCount   = failCount;

endmodule
